// File: rtl/der_pkg.sv
// rtl/der_pkg.sv - shared encodings for the drawing-engine misc pipe
package der_pkg;

  // Cache-ready FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RDY  = 2'd2
  } cardy_state_e;

  // Pixel size select codes
  localparam logic [1:0] PS_8   = 2'b00;
  localparam logic [1:0] PS_16  = 2'b01;
  localparam logic [1:0] PS_565 = 2'b11;
  localparam logic [1:0] PS_32  = 2'b10;

  // Width of one tiled origin channel
  localparam int TILE_W = 28;

endpackage

// File: rtl/der_cardy_fsm.sv
// rtl/der_cardy_fsm.sv - cache-ready sequencer with programmable delay
module der_cardy_fsm
  import der_pkg::*;
#(
  parameter int RDY_DLY = 3
) (
  input  logic de_clk,
  input  logic rstn,
  input  logic cr_pulse,
  input  logic ca_inv,
  input  logic bc_co,
  output logic ca_rdy
);

  // Counter starts one below the delay so the RDY transition lands RDY_DLY edges after the request
  localparam logic [3:0] RELOAD = 4'(RDY_DLY - 1);

  cardy_state_e r_state;
  cardy_state_e w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;

  // State and countdown registers
  always_ff @(posedge de_clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, countdown and ready output; invalidate beats any request
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    ca_rdy      = (r_state == ST_RDY) | bc_co;
    if (ca_inv) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cr_pulse) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = RELOAD;
          end
        end
        ST_WAIT: begin
          if (cr_pulse) begin
            w_cnt_nxt = RELOAD;
          end else if (r_cnt == 4'd0) begin
            w_state_nxt = ST_RDY;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        ST_RDY: begin
          w_state_nxt = ST_RDY;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/der_misc_pipe.sv
// rtl/der_misc_pipe.sv - origin registers, pixel decode and cache-ready top
module der_misc_pipe
  import der_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int ORG_W   = 26,
  parameter int RDY_DLY = 3
) (
  input  logic                  de_clk,
  input  logic                  rstn,
  input  logic                  prst,
  input  logic                  cr_pulse,
  input  logic                  ca_inv,
  input  logic                  bc_co,
  input  logic [1:0]            ps_sel,
  input  logic [1:0]            apat,
  input  logic [NCH*32-1:0]     org_in,
  input  logic                  org_sel,
  input  logic                  org_vld,
  input  logic                  de_busy,
  output logic                  org_rdy,
  output logic                  prst_1,
  output logic                  ca_rdy,
  output logic                  ps8s,
  output logic                  ps16s,
  output logic                  ps565s,
  output logic                  ps32s,
  output logic [NCH*32-1:0]     de_org,
  output logic [NCH*TILE_W-1:0] org,
  output logic                  or_apat
);

  logic                  r_prst_1;
  logic [NCH*32-1:0]     r_org_q;
  logic                  r_sel_q;
  logic                  w_load;
  logic [NCH*TILE_W-1:0] w_org;

  // Origins are frozen while the engine runs, independent of the load request
  assign org_rdy = ~de_busy;
  assign w_load  = org_vld & ~de_busy;

  // Pattern-reset delay and whole-origin capture
  always_ff @(posedge de_clk) begin
    if (!rstn) begin
      r_prst_1 <= 1'b0;
      r_org_q  <= '0;
      r_sel_q  <= 1'b0;
    end else begin
      r_prst_1 <= prst;
      if (w_load) begin
        r_org_q <= org_in;
        r_sel_q <= org_sel;
      end
    end
  end

  assign prst_1  = r_prst_1;
  assign or_apat = |apat;
  assign ps8s    = (ps_sel == PS_8);
  assign ps16s   = (ps_sel == PS_16);
  assign ps565s  = (ps_sel == PS_565);
  assign ps32s   = (ps_sel == PS_32);
  assign de_org  = r_sel_q ? r_org_q : '0;

  // Tiled view drops the low nibble and keeps ORG_W-4 significant bits per channel
  always_comb begin
    w_org = '0;
    if (!r_sel_q) begin
      for (int k = 0; k < NCH; k++) begin
        w_org[k*TILE_W +: ORG_W-4] = r_org_q[k*32+4 +: ORG_W-4];
      end
    end
  end

  assign org = w_org;

  der_cardy_fsm #(
    .RDY_DLY (RDY_DLY)
  ) u_cardy (
    .de_clk   (de_clk),
    .rstn     (rstn),
    .cr_pulse (cr_pulse),
    .ca_inv   (ca_inv),
    .bc_co    (bc_co),
    .ca_rdy   (ca_rdy)
  );

endmodule
